// File: rtl/tetris_pkg.sv
// Piece codes and bag constants shared by the sequencer
// and the spawn stage.
package tetris_pkg;

    typedef enum logic [2:0] {
        LINE      = 3'd0,
        SMASHBOY  = 3'd1,
        L         = 3'd2,
        REVERSE_L = 3'd3,
        S         = 3'd4,
        Z         = 3'd5,
        T         = 3'd6
    } block_t;

    localparam int NUM_PIECES = 7;
    localparam logic [6:0] BAG_FULL = 7'h7F;

    // Lowest-index code whose used bit is clear.
    function automatic block_t lowest_free(input logic [6:0] used);
        block_t b;
        b = LINE;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!used[i]) begin
                b = block_t'(i[2:0]);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11,
// with an entropy bit folded into the feedback.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        entropy,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[15] ^ q[13] ^ q[12] ^ q[10] ^ entropy;

    // An all-zero state would lock up, so a zero seed becomes 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// 7-bag tetromino sequencer: current piece plus one preview,
// LFSR candidates with a bounded-retry fallback pick.
module piece_sequencer
    import tetris_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_REJECT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entropy,
    input  logic       spawn_req,
    output logic [2:0] current_piece,
    output logic [2:0] next_piece,
    output logic       piece_valid
);

    typedef enum logic [1:0] {
        DRAW_CUR,
        DRAW_NEXT,
        READY
    } state_t;

    localparam logic [3:0] REJ_MAX = 4'(MAX_REJECT);

    state_t      state, state_d;
    logic [6:0]  used, used_d, used_set;
    logic [7:0]  used_x;
    logic [3:0]  rej, rej_d;
    logic [2:0]  cur_d, nxt_d;
    logic [2:0]  cand, pick;
    logic        pick_ok;
    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (LFSR_SEED),
        .entropy (entropy),
        .q       (lfsr)
    );

    assign cand        = lfsr[2:0];
    assign lfsr_unused = ^lfsr[15:3];
    // Code 7 maps onto a permanently-set bit, so one lookup rejects it.
    assign used_x      = {1'b1, used};
    assign piece_valid = (state == READY);

    always_comb begin
        state_d  = state;
        used_d   = used;
        rej_d    = rej;
        cur_d    = current_piece;
        nxt_d    = next_piece;
        pick     = cand;
        pick_ok  = 1'b0;
        used_set = used;

        if (state != READY) begin
            if (rej == REJ_MAX) begin
                pick    = lowest_free(used);
                pick_ok = 1'b1;
            end else if (!used_x[cand]) begin
                pick_ok = 1'b1;
            end else begin
                rej_d = rej + 4'd1;
            end
        end

        if (pick_ok) begin
            used_set = used | (7'd1 << pick);
            used_d   = (used_set == BAG_FULL) ? 7'h00 : used_set;
            rej_d    = 4'd0;
        end

        unique case (state)
            DRAW_CUR: begin
                if (pick_ok) begin
                    cur_d   = pick;
                    state_d = DRAW_NEXT;
                end
            end
            DRAW_NEXT: begin
                if (pick_ok) begin
                    nxt_d   = pick;
                    state_d = READY;
                end
            end
            READY: begin
                if (spawn_req) begin
                    cur_d   = next_piece;
                    state_d = DRAW_NEXT;
                end
            end
            default: state_d = DRAW_CUR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= DRAW_CUR;
            used          <= 7'h00;
            rej           <= 4'd0;
            current_piece <= 3'd0;
            next_piece    <= 3'd0;
        end else begin
            state         <= state_d;
            used          <= used_d;
            rej           <= rej_d;
            current_piece <= cur_d;
            next_piece    <= nxt_d;
        end
    end

endmodule

// File: doc/piece_sequencer.md
# piece_sequencer

Generates the stream of tetromino type codes that drives the spawn stage: it presents the current piece (the 3-bit code the spawn stage turns into the initial 22x10 display array) and a one-piece preview. Pieces come from a 7-bag randomizer: every group of seven consecutive draws is a permutation of codes 0..6. A free-running 16-bit LFSR supplies candidates, and a bounded-retry fallback caps draw latency. It sits directly upstream of the spawn stage and is advanced by the game controller whenever a new piece is needed.

## Interface
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset; a value of 0 is replaced by 16'h0001.
- MAX_REJECT, 8, number of rejected candidates tolerated before the fallback pick (0..15).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- entropy  input  1  XORed into the LFSR feedback bit every cycle (e.g. raw button level); tie to 0 for deterministic runs.
- spawn_req  input  1  single-cycle request to advance the sequence; honoured only while piece_valid=1.
- current_piece  output  3  type code of the piece to spawn now (LINE=0, SMASHBOY=1, L=2, REVERSE_L=3, S=4, Z=5, T=6).
- next_piece  output  3  preview code.
- piece_valid  output  1  current_piece and next_piece are stable, and spawn_req will be accepted.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Feedback is the XOR of those taps XOR entropy. It shifts every cycle in every state, reset excluded.
- Bag mask: 7-bit used[6:0], cleared at reset.
- Candidate: lfsr[2:0]. It is rejected if it equals 7 or if used[candidate]=1.
- FSM states: DRAW_CUR, DRAW_NEXT, READY.
- Reset:
  - state goes to DRAW_CUR.
  - used, reject counter, current_piece and next_piece go to 0.
  - piece_valid goes to 0.
- Draw cycle, in DRAW_CUR or DRAW_NEXT:
  - If the candidate is accepted, write it to the target register and set its used bit.
  - Otherwise increment the reject counter.
  - When the reject counter equals MAX_REJECT, the cycle instead takes the lowest-index unused code, without checking the candidate.
  - Any successful pick clears the reject counter.
  - If setting the bit would make used=7'h7F, used becomes 7'h00 in the same edge, starting a new bag.
- Transitions:
  - DRAW_CUR goes to DRAW_NEXT on a pick.
  - DRAW_NEXT goes to READY on a pick.
  - READY with spawn_req=1: current_piece takes next_piece, then go to DRAW_NEXT.
- piece_valid is 1 exactly in READY.
- Ignored requests: spawn_req while piece_valid=0 is dropped, not queued. It is also dropped in the cycle that DRAW_NEXT completes, because piece_valid was still 0 in that cycle.
- Arithmetic: the reject counter is 4 bits and saturates at MAX_REJECT. The lowest-unused search is a priority encoder over ~used.

## Timing
- Draw latency is 1 to MAX_REJECT+1 cycles per piece.
- After rst_n rises, piece_valid asserts within 2 to 2*(MAX_REJECT+1) cycles.
- A spawn_req sampled high in READY produces, at the next edge:
  - current_piece updated;
  - piece_valid=0.
- piece_valid reasserts 1 to MAX_REJECT+1 cycles later.
- Outputs are registered; there is no combinational path from input to output.
- Reset mid-draw: at the next edge all outputs and state return to their reset values, and the partial bag is discarded.

## Structure
- Shared package tetris_pkg holds:
  - block_t enum, 3 bits, LINE..T = 0..6, shared with the spawn stage;
  - NUM_PIECES=7;
  - BAG_FULL=7'h7F.
- One sub-module, lfsr16 (clk, rst_n, seed, entropy, q[15:0]), which handles the zero-seed substitution.
- The bag, FSM and reject logic stay in piece_sequencer.

## Test plan
- Reset: hold rst_n=0 for 5 cycles. Required: current_piece=0, next_piece=0 and piece_valid=0 every cycle; after release, piece_valid=1 within 2*(MAX_REJECT+1) cycles.
- Bag property: with entropy=0 and default seed, issue 21 spawns, each in READY. Required: the drawn sequence, starting with the first current_piece, splits into three groups of 7 that are each a permutation of {0..6}, and code 7 never appears.
- Fallback: MAX_REJECT=0. Required: the sequence is 0,1,2,3,4,5,6,0,1,... regardless of LFSR; piece_valid asserts exactly 2 cycles after reset; each spawn drops valid for exactly 1 cycle.
- Ignored request: pulse spawn_req while piece_valid=0, including the DRAW_NEXT completion cycle. Required: current_piece is unchanged and no extra piece is consumed from the bag.
- Reset mid-draw: assert rst_n=0 one cycle after a spawn. Required: outputs are 0/0/0 at the next edge; the following bag is a full fresh permutation of 7.
- Zero seed: LFSR_SEED=16'h0000. Required: the LFSR never holds 0 over 1000 cycles, and pieces keep arriving.
